// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern source that shifts SEQ out MSB-first, repeating rep_n times with optional gaps.
// Optional SEQ_PATTERN_TX_LAST_EN adds a registered 'last' flag on the final bit of each repetition.
module seq_pattern_tx #(
  parameter int                SEQ_W = 5,
  parameter logic [SEQ_W-1:0]  SEQ   = 5'b10111,
  parameter int                GAP   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] rep_n,
  input  logic       abort,
  output logic       data,
  output logic       data_vld,
  output logic       busy,
  output logic       done
`ifdef SEQ_PATTERN_TX_LAST_EN
  ,
  output logic       last
`endif
);
  localparam int BW = (SEQ_W > 1) ? $clog2(SEQ_W) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(SEQ_W - 1);
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;
  state_t           r_state;
  logic [SEQ_W-2:0] r_shreg;
  logic [BW-1:0]    r_bit_cnt;
  logic [7:0]       r_rep_cnt;
  logic [3:0]       r_gap_cnt;
  // r_shreg holds only the bits still to come; the current bit lives in data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_rep_cnt <= '0;
      r_gap_cnt <= '0;
      data      <= 1'b0;
      data_vld  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_PATTERN_TX_LAST_EN
      last      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef SEQ_PATTERN_TX_LAST_EN
      last <= 1'b0;
`endif
      if (abort && (r_state == S_SEND || r_state == S_GAP)) begin
        r_state   <= S_IDLE;
        r_shreg   <= '0;
        r_bit_cnt <= '0;
        r_rep_cnt <= '0;
        r_gap_cnt <= '0;
        data      <= 1'b0;
        data_vld  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              if (rep_n == 8'd0) begin
                done <= 1'b1;
              end else begin
                r_state   <= S_SEND;
                r_rep_cnt <= rep_n;
                r_shreg   <= SEQ[SEQ_W-2:0];
                r_bit_cnt <= '0;
                data      <= SEQ[SEQ_W-1];
                data_vld  <= 1'b1;
                busy      <= 1'b1;
              end
            end
          end
          S_SEND: begin
            if (r_bit_cnt != LAST_BIT) begin
              r_shreg   <= r_shreg << 1;
              data      <= r_shreg[SEQ_W-2];
              r_bit_cnt <= r_bit_cnt + 1'b1;
`ifdef SEQ_PATTERN_TX_LAST_EN
              last      <= (r_bit_cnt == LAST_BIT - 1'b1);
`endif
            end else begin
              r_rep_cnt <= r_rep_cnt - 8'd1;
              r_bit_cnt <= '0;
              if (r_rep_cnt == 8'd1) begin
                r_state  <= S_IDLE;
                data     <= 1'b0;
                data_vld <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else if (GAP == 0) begin
                r_shreg <= SEQ[SEQ_W-2:0];
                data    <= SEQ[SEQ_W-1];
              end else begin
                r_state   <= S_GAP;
                r_gap_cnt <= 4'(GAP);
                data      <= 1'b0;
                data_vld  <= 1'b0;
              end
            end
          end
          S_GAP: begin
            if (r_gap_cnt <= 4'd1) begin
              r_state   <= S_SEND;
              r_gap_cnt <= '0;
              r_shreg   <= SEQ[SEQ_W-2:0];
              data      <= SEQ[SEQ_W-1];
              data_vld  <= 1'b1;
            end else begin
              r_gap_cnt <= r_gap_cnt - 4'd1;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_rep_cnt <= '0;
            r_gap_cnt <= '0;
            data      <= 1'b0;
            data_vld  <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed scoreboard bench for seq_pattern_tx, default GAP=0 and GAP=2 instances side by side.
module tb_seq_pattern_tx;
  typedef struct packed {logic d; logic v; logic b; logic n;} exp_t;
  localparam logic [4:0] PAT = 5'b10111;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] rep_n = 8'd0;
  logic d0, v0, b0, n0, d2, v2, b2, n2;
  exp_t q0[$], q2[$];
  int total = 0, bad = 0, det = 0;
  logic [4:0] sh = '0;
  seq_pattern_tx u0 (.clk(clk), .rst(rst), .start(start), .rep_n(rep_n), .abort(abort),
                     .data(d0), .data_vld(v0), .busy(b0), .done(n0));
  seq_pattern_tx #(.GAP(2)) u2 (.clk(clk), .rst(rst), .start(start), .rep_n(rep_n), .abort(abort),
                     .data(d2), .data_vld(v2), .busy(b2), .done(n2));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input exp_t obs, input exp_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got={d,v,busy,done}=%b want=%b", tag, obs, exp);
    end
  endtask
  task automatic add(input int w, input exp_t e);
    if (w == 0) q0.push_back(e);
    else q2.push_back(e);
  endtask
  task automatic push(input int w, input int r, input int g);
    for (int k = 0; k < r; k++) begin
      for (int i = 4; i >= 0; i--) add(w, {PAT[i], 1'b1, 1'b1, 1'b0});
      if (k < r - 1) for (int j = 0; j < g; j++) add(w, 4'b0010);
    end
    add(w, 4'b0001);
  endtask
  task automatic observe();
    exp_t e;
    e = '0;
    if (q0.size() > 0) e = q0.pop_front();
    chk("gap0", {d0, v0, b0, n0}, e);
    e = '0;
    if (q2.size() > 0) e = q2.pop_front();
    chk("gap2", {d2, v2, b2, n2}, e);
    if (v0) begin
      sh = {sh[3:0], d0};
      if (sh == PAT) begin
        det++;
        sh = '0;
      end
    end
  endtask
  task automatic step(input logic s, input logic [7:0] r, input logic a);
    @(negedge clk);
    observe();
    start = s;
    rep_n = r;
    abort = a;
    if (a) begin
      q0.delete();
      q2.delete();
    end else if (s) begin
      if (q0.size() == 0) push(0, int'(r), 0);
      if (q2.size() == 0) push(2, int'(r), 2);
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (q0.size() == 0 && q2.size() == 0) break;
      step(1'b0, 8'd0, 1'b0);
    end
    total++;
    assert (q0.size() == 0 && q2.size() == 0) else begin
      bad++;
      $error("FAIL drain got=%0d/%0d pending want=0", q0.size(), q2.size());
    end
    step(1'b0, 8'd0, 1'b0);
  endtask
  initial begin
    #3;
    chk("rst0", {d0, v0, b0, n0}, '0);
    chk("rst2", {d2, v2, b2, n2}, '0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    drain();
    det = 0;
    sh = '0;
    step(1'b1, 8'd3, 1'b0);
    step(1'b1, 8'd5, 1'b0);
    drain();
    total++;
    assert (det == 3) else begin
      bad++;
      $error("FAIL detect got=%0d want=3", det);
    end
    step(1'b1, 8'd2, 1'b0);
    drain();
    step(1'b1, 8'd0, 1'b0);
    drain();
    step(1'b1, 8'd1, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd3, 1'b0);
    repeat (2) step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    repeat (3) step(1'b0, 8'd9, 1'b0);
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    drain();
    step(1'b1, 8'd2, 1'b0);
    repeat (3) step(1'b0, 8'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst0", {d0, v0, b0, n0}, '0);
    chk("arst2", {d2, v2, b2, n2}, '0);
    rst = 1'b0;
    q0.delete();
    q2.delete();
    step(1'b0, 8'd0, 1'b0);
    step(1'b1, 8'd1, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
